axi4_slave_write_arbiter: RTL and testbench

AXI4_SLAVE_WRITE_ARBITER -- requirements
Module: axi4_slave_write_arbiter

---
 rtl/axi4_slave_write_arbiter_if.sv | 53 +++++
 rtl/axi4_slave_write_arbiter.sv | 178 +++++++++++++++++
 tb/tb_axi4_slave_write_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_write_arbiter_if.sv
// Bundle of the master-side and slave-side AXI4 write channels and status seen by the write arbiter.
// The arbiter connects through the slave modport, and the surrounding masters/slave connect through the master modport.
interface axi4_slave_write_arbiter_if #(
   parameter int MASTER_NUM = 4,
   parameter int W_ID_LEN   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   localparam int EXTRA_ID_LEN = $clog2(MASTER_NUM);
   localparam int SID_W        = EXTRA_ID_LEN + W_ID_LEN;

   logic [MASTER_NUM*W_ID_LEN-1:0]     M_AWID;
   logic [MASTER_NUM*ADDR_WIDTH-1:0]   M_AWADDR;
   logic [MASTER_NUM*8-1:0]            M_AWLEN;
   logic [MASTER_NUM-1:0]              M_AWVALID;
   logic [MASTER_NUM-1:0]              M_AWREADY;
   logic [MASTER_NUM*DATA_WIDTH-1:0]   M_WDATA;
   logic [MASTER_NUM*DATA_WIDTH/8-1:0] M_WSTRB;
   logic [MASTER_NUM-1:0]              M_WLAST;
   logic [MASTER_NUM-1:0]              M_WVALID;
   logic [MASTER_NUM-1:0]              M_WREADY;

   logic [SID_W-1:0]                   S_AWID;
   logic [ADDR_WIDTH-1:0]              S_AWADDR;
   logic [7:0]                         S_AWLEN;
   logic                               S_AWVALID;
   logic                               S_AWREADY;
   logic [DATA_WIDTH-1:0]              S_WDATA;
   logic [DATA_WIDTH/8-1:0]            S_WSTRB;
   logic                               S_WLAST;
   logic                               S_WVALID;
   logic                               S_WREADY;

   logic [EXTRA_ID_LEN-1:0]            GRANT_IDX;
   logic                               BUSY;
   logic                               WLAST_ERR;

   modport slave (
      input  M_AWID, M_AWADDR, M_AWLEN, M_AWVALID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
      output M_AWREADY, M_WREADY,
      output S_AWID, S_AWADDR, S_AWLEN, S_AWVALID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
      input  S_AWREADY, S_WREADY,
      output GRANT_IDX, BUSY, WLAST_ERR
   );

   modport master (
      output M_AWID, M_AWADDR, M_AWLEN, M_AWVALID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
      input  M_AWREADY, M_WREADY,
      input  S_AWID, S_AWADDR, S_AWLEN, S_AWVALID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
      output S_AWREADY, S_WREADY,
      input  GRANT_IDX, BUSY, WLAST_ERR
   );
endinterface

// File: rtl/axi4_slave_write_arbiter.sv
// Round-robin N:1 AXI4 write arbiter: one burst at a time, AW accepted before any W beat is forwarded.
// Optional macro AXI4_ARB_BEAT_CHECK_EN: S_WLAST comes from a beat counter and a sticky WLAST_ERR flags master disagreement.
//
// state   | meaning
// IDLE    | no burst; pick first requester at/after rr_ptr and latch its AW fields
// ADDR    | present latched AW to slave; wait for S_AWREADY
// DATA    | forward W beats of the granted master until the last beat handshakes
module axi4_slave_write_arbiter #(
   parameter int MASTER_NUM = 4,
   parameter int W_ID_LEN   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input logic                       ACLK,
   input logic                       ARESETn,
   axi4_slave_write_arbiter_if.slave bus
);
   localparam int EXTRA_ID_LEN = $clog2(MASTER_NUM);
   localparam int STRB_WIDTH   = DATA_WIDTH / 8;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [EXTRA_ID_LEN-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, next_ptr;
   logic [W_ID_LEN-1:0]     awid_q, awid_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [7:0]              awlen_q, awlen_d;

   logic                    req_found;
   logic [EXTRA_ID_LEN-1:0] req_idx, cand_idx;
   int                      arb_cand;
   logic [W_ID_LEN-1:0]     req_awid;
   logic [ADDR_WIDTH-1:0]   req_awaddr;
   logic [7:0]              req_awlen;
   logic [DATA_WIDTH-1:0]   g_wdata;
   logic [STRB_WIDTH-1:0]   g_wstrb;
   logic                    g_wvalid, g_wlast, s_wlast, w_hs;

   // Round-robin search plus field muxes, written with constant indices only.
   always_comb begin
      req_found  = 1'b0;
      req_idx    = '0;
      cand_idx   = '0;
      arb_cand   = 0;
      req_awid   = '0;
      req_awaddr = '0;
      req_awlen  = '0;
      g_wdata    = '0;
      g_wstrb    = '0;
      g_wvalid   = 1'b0;
      g_wlast    = 1'b0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         arb_cand = int'(rr_ptr_q) + i;
         if (arb_cand >= MASTER_NUM) arb_cand = arb_cand - MASTER_NUM;
         cand_idx = EXTRA_ID_LEN'(arb_cand);
         if (!req_found && bus.M_AWVALID[cand_idx]) begin
            req_found = 1'b1;
            req_idx   = cand_idx;
         end
      end
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (req_idx == EXTRA_ID_LEN'(i)) begin
            req_awid   = bus.M_AWID[i*W_ID_LEN +: W_ID_LEN];
            req_awaddr = bus.M_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            req_awlen  = bus.M_AWLEN[i*8 +: 8];
         end
         if (grant_q == EXTRA_ID_LEN'(i)) begin
            g_wdata  = bus.M_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
            g_wstrb  = bus.M_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
            g_wvalid = bus.M_WVALID[i];
            g_wlast  = bus.M_WLAST[i];
         end
      end
   end

   assign next_ptr = (int'(grant_q) == MASTER_NUM - 1) ? '0 : grant_q + 1'b1;
   assign w_hs     = (state_q == ST_DATA) && g_wvalid && bus.S_WREADY;

`ifdef AXI4_ARB_BEAT_CHECK_EN
   logic [7:0] beat_cnt_q, beat_cnt_d;
   logic       wlast_err_q, wlast_err_d;

   assign s_wlast = (beat_cnt_q == awlen_q);

   always_comb begin
      beat_cnt_d  = beat_cnt_q;
      wlast_err_d = wlast_err_q;
      if (state_q == ST_ADDR && bus.S_AWREADY) beat_cnt_d = '0;
      else if (w_hs)                           beat_cnt_d = beat_cnt_q + 8'd1;
      if (w_hs && (g_wlast != s_wlast))        wlast_err_d = 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         beat_cnt_q  <= '0;
         wlast_err_q <= 1'b0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         wlast_err_q <= wlast_err_d;
      end
   end

   assign bus.WLAST_ERR = wlast_err_q;
`else
   assign s_wlast       = g_wlast;
   assign bus.WLAST_ERR = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      awid_d        = awid_q;
      awaddr_d      = awaddr_q;
      awlen_d       = awlen_q;
      bus.M_AWREADY = '0;
      bus.M_WREADY  = '0;
      bus.S_AWVALID = 1'b0;
      bus.S_WVALID  = 1'b0;
      bus.S_WDATA   = '0;
      bus.S_WSTRB   = '0;
      bus.S_WLAST   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_found) begin
               state_d  = ST_ADDR;
               grant_d  = req_idx;
               awid_d   = req_awid;
               awaddr_d = req_awaddr;
               awlen_d  = req_awlen;
            end
         end
         ST_ADDR: begin
            bus.S_AWVALID = 1'b1;
            for (int i = 0; i < MASTER_NUM; i++)
               bus.M_AWREADY[i] = (grant_q == EXTRA_ID_LEN'(i)) && bus.S_AWREADY;
            if (bus.S_AWREADY) state_d = ST_DATA;
         end
         ST_DATA: begin
            bus.S_WVALID = g_wvalid;
            bus.S_WDATA  = g_wdata;
            bus.S_WSTRB  = g_wstrb;
            bus.S_WLAST  = s_wlast;
            for (int i = 0; i < MASTER_NUM; i++)
               bus.M_WREADY[i] = (grant_q == EXTRA_ID_LEN'(i)) && bus.S_WREADY;
            if (w_hs && s_wlast) begin
               state_d  = ST_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         awid_q   <= '0;
         awaddr_q <= '0;
         awlen_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         awid_q   <= awid_d;
         awaddr_q <= awaddr_d;
         awlen_q  <= awlen_d;
      end
   end

   assign bus.S_AWID    = {grant_q, awid_q};
   assign bus.S_AWADDR  = awaddr_q;
   assign bus.S_AWLEN   = awlen_q;
   assign bus.GRANT_IDX = grant_q;
   assign bus.BUSY      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_axi4_slave_write_arbiter.sv
// Self-checking bench for axi4_slave_write_arbiter: grant table, hand-written corner sequences,
// and randomized multi-master traffic checked against a burst-level round-robin reference model.
module tb_axi4_slave_write_arbiter;
   localparam int N   = 4;
   localparam int IDW = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi4_slave_write_arbiter_if #(.MASTER_NUM(N), .W_ID_LEN(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi4_slave_write_arbiter #(.MASTER_NUM(N), .W_ID_LEN(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK    (clk),
      .ARESETn (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] mask;
      int         exp_g;
   } vec_t;
   vec_t tab[9];

   int nb[N], ak[N], wk[N], wb[N], served[N];
   int lens[N][8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] wpat(input int i, input int k, input int b);
      return {16'hC0DE, 8'(i), 8'(k), 16'(b), 16'(i*7 + k*3 + b)};
   endfunction
   function automatic logic [7:0] spat(input int i, input int k, input int b);
      return 8'(i*16 + k + b);
   endfunction
   function automatic logic [3:0] idof(input int i, input int k);
      return 4'(i*5 + k*3 + 1);
   endfunction
   function automatic logic [31:0] adof(input int i, input int k);
      return 32'h4000_0000 + 32'(i*256 + k*16);
   endfunction

   task automatic drv_aw(input int i, input logic v, input logic [3:0] id, input logic [31:0] a, input logic [7:0] l);
      bus.M_AWVALID[i]        = v;
      bus.M_AWID[i*IDW +: IDW] = id;
      bus.M_AWADDR[i*AW +: AW] = a;
      bus.M_AWLEN[i*8 +: 8]    = l;
   endtask

   task automatic drv_w(input int i, input logic v, input logic [63:0] d, input logic [7:0] s, input logic l);
      bus.M_WVALID[i]          = v;
      bus.M_WDATA[i*DW +: DW]  = d;
      bus.M_WSTRB[i*8 +: 8]    = s;
      bus.M_WLAST[i]           = l;
   endtask

   task automatic clear_inputs();
      bus.M_AWID = '0; bus.M_AWADDR = '0; bus.M_AWLEN = '0; bus.M_AWVALID = '0;
      bus.M_WDATA = '0; bus.M_WSTRB = '0; bus.M_WLAST = '0; bus.M_WVALID = '0;
      bus.S_AWREADY = 1'b0; bus.S_WREADY = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_busy",      64'(bus.BUSY),      64'd0);
      chk("rst_grant",     64'(bus.GRANT_IDX), 64'd0);
      chk("rst_s_awvalid", 64'(bus.S_AWVALID), 64'd0);
      chk("rst_s_awid",    64'(bus.S_AWID),    64'd0);
      chk("rst_wlast_err", 64'(bus.WLAST_ERR), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Single-beat burst from every master in mask; checks 3-cycle timing and the expected grant.
   task automatic run_single(input logic [3:0] mask, input int g);
      logic [3:0] oh;
      oh = 4'(1 << g);
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         drv_aw(i, mask[i], idof(i, 9), adof(i, 9), 8'd0);
         drv_w(i, mask[i], wpat(i, 9, 0), spat(i, 9, 0), 1'b1);
      end
      bus.S_AWREADY = 1'b1;
      bus.S_WREADY  = 1'b1;
      @(negedge clk);
      chk("tab_idle_busy", 64'(bus.BUSY), 64'd0);
      @(posedge clk); #1;
      bus.M_AWVALID = '0;
      @(negedge clk);
      chk("tab_grant",     64'(bus.GRANT_IDX), 64'(g));
      chk("tab_s_awvalid", 64'(bus.S_AWVALID), 64'd1);
      chk("tab_s_awid",    64'(bus.S_AWID),    64'({2'(g), idof(g, 9)}));
      chk("tab_s_awaddr",  64'(bus.S_AWADDR),  64'(adof(g, 9)));
      chk("tab_m_awready", 64'(bus.M_AWREADY), 64'(oh));
      chk("tab_addr_wv",   64'(bus.S_WVALID),  64'd0);
      chk("tab_addr_mwr",  64'(bus.M_WREADY),  64'd0);
      @(negedge clk);
      chk("tab_s_wvalid",  64'(bus.S_WVALID),  64'd1);
      chk("tab_s_wdata",   bus.S_WDATA,        wpat(g, 9, 0));
      chk("tab_s_wlast",   64'(bus.S_WLAST),   64'd1);
      chk("tab_m_wready",  64'(bus.M_WREADY),  64'(oh));
      chk("tab_data_awr",  64'(bus.M_AWREADY), 64'd0);
      @(negedge clk);
      chk("tab_end_busy",  64'(bus.BUSY),      64'd0);
      chk("tab_wlast_err", 64'(bus.WLAST_ERR), 64'd0);
      @(posedge clk); #1;
      bus.M_WVALID = '0;
   endtask

   task automatic apply_rand();
      for (int i = 0; i < N; i++) begin
         if (ak[i] < nb[i]) drv_aw(i, 1'b1, idof(i, ak[i]), adof(i, ak[i]), 8'(lens[i][ak[i]]));
         else               drv_aw(i, 1'b0, 4'd0, 32'd0, 8'd0);
         if (wk[i] < nb[i])
            drv_w(i, ($urandom_range(0, 3) != 0), wpat(i, wk[i], wb[i]), spat(i, wk[i], wb[i]),
                  (wb[i] == lens[i][wk[i]]));
         else
            drv_w(i, 1'b0, 64'd0, 8'd0, 1'b0);
      end
      bus.S_AWREADY = ($urandom_range(0, 2) != 0);
      bus.S_WREADY  = ($urandom_range(0, 2) != 0);
   endtask

   initial begin
      int beats, total, done_b, ptr, cur_m, cur_k, cur_b, exp_m, cand;
      bit in_data, hit, aw_acc;
      logic [3:0] exp_aw, exp_w, aw_hs, w_hs;

      tab[0] = '{4'b0101, 0};
      tab[1] = '{4'b0101, 2};
      tab[2] = '{4'b0001, 0};
      tab[3] = '{4'b1000, 3};
      tab[4] = '{4'b1111, 0};
      tab[5] = '{4'b1100, 2};
      tab[6] = '{4'b0110, 1};
      tab[7] = '{4'b0010, 1};
      tab[8] = '{4'b1010, 3};

      do_reset();
      for (int v = 0; v < 9; v++) run_single(tab[v].mask, tab[v].exp_g);

      // All four requesting continuously: strict rotation 0,1,2,3,0,1,2,3.
      do_reset();
      for (int v = 0; v < 8; v++) run_single(4'b1111, v % N);

      // Master 1, 4-beat burst, slave WREADY toggling; next arbitration must start at master 2.
      do_reset();
      @(posedge clk); #1;
      drv_aw(1, 1'b1, 4'h6, 32'h1100, 8'd3);
      drv_w(1, 1'b1, wpat(1, 0, 0), 8'hFF, 1'b0);
      bus.S_AWREADY = 1'b1;
      bus.S_WREADY  = 1'b0;
      beats = 0; hit = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         aw_acc = bus.M_AWREADY[1];
         if (bus.BUSY) hit = 1;
         if (bus.S_WVALID && bus.S_WREADY) begin
            chk("len3_wdata", bus.S_WDATA, wpat(1, 0, beats));
            chk("len3_wlast", 64'(bus.S_WLAST), 64'(beats == 3));
            beats++;
         end else if (hit && !bus.BUSY) break;
         @(posedge clk); #1;
         if (aw_acc) bus.M_AWVALID[1] = 1'b0;
         drv_w(1, (beats < 4), wpat(1, 0, beats), 8'hFF, (beats == 3));
         bus.S_WREADY = ~bus.S_WREADY;
      end
      chk("len3_beats", 64'(beats), 64'd4);
      chk("len3_idle",  64'(bus.BUSY), 64'd0);
      run_single(4'b1111, 2);

      // W valid from master 3 before its AW is accepted must stall.
      do_reset();
      @(posedge clk); #1;
      drv_aw(3, 1'b1, 4'h9, 32'h3300, 8'd0);
      drv_w(3, 1'b1, wpat(3, 0, 0), 8'hFF, 1'b1);
      bus.S_WREADY = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("early_w_mwready", 64'(bus.M_WREADY), 64'd0);
         chk("early_w_swvalid", 64'(bus.S_WVALID), 64'd0);
      end
      @(posedge clk); #1;
      bus.S_AWREADY = 1'b1;
      @(negedge clk);
      chk("early_w_awready", 64'(bus.M_AWREADY), 64'h8);
      @(posedge clk); #1;
      bus.M_AWVALID = '0;
      @(negedge clk);
      chk("early_w_fwd",   64'(bus.S_WVALID), 64'd1);
      chk("early_w_data",  bus.S_WDATA, wpat(3, 0, 0));
      chk("early_w_ready", 64'(bus.M_WREADY), 64'h8);
      @(posedge clk); #1;
      bus.M_WVALID = '0;

      // Reset during beat 2 of an 8-beat burst from master 2.
      do_reset();
      @(posedge clk); #1;
      drv_aw(2, 1'b1, 4'h7, 32'h2000, 8'd7);
      drv_w(2, 1'b1, wpat(2, 0, 0), 8'hFF, 1'b0);
      bus.S_AWREADY = 1'b1;
      bus.S_WREADY  = 1'b1;
      beats = 0; hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk);
         aw_acc = bus.M_AWREADY[2];
         if (bus.S_WVALID && bus.S_WREADY) begin
            beats++;
            if (beats == 2) begin
               #2;
               rst_n = 1'b0;
               #1;
               hit = 1;
               chk("midrst_busy",    64'(bus.BUSY),      64'd0);
               chk("midrst_swvalid", 64'(bus.S_WVALID),  64'd0);
               chk("midrst_mwready", 64'(bus.M_WREADY),  64'd0);
               chk("midrst_awvalid", 64'(bus.S_AWVALID), 64'd0);
               chk("midrst_awready", 64'(bus.M_AWREADY), 64'd0);
               chk("midrst_grant",   64'(bus.GRANT_IDX), 64'd0);
               chk("midrst_awid",    64'(bus.S_AWID),    64'd0);
               chk("midrst_wdata",   bus.S_WDATA,        64'd0);
            end
         end
         if (!hit) begin
            @(posedge clk); #1;
            if (aw_acc) bus.M_AWVALID[2] = 1'b0;
            drv_w(2, 1'b1, wpat(2, 0, beats), 8'hFF, 1'b0);
         end
      end
      chk("midrst_reached", 64'(hit), 64'd1);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk("midrst_no_beat", 64'(bus.S_WVALID), 64'd0);
      end
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      run_single(4'b1111, 0);

      // Randomized traffic against the burst-level model.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         total = 0;
         for (int i = 0; i < N; i++) begin
            nb[i] = $urandom_range(0, 5);
            ak[i] = 0; wk[i] = 0; wb[i] = 0; served[i] = 0;
            for (int k = 0; k < 8; k++) lens[i][k] = $urandom_range(0, 3);
            total += nb[i];
         end
         if (total == 0) begin nb[0] = 1; total = 1; end
         ptr = 0; in_data = 0; done_b = 0; cur_m = 0; cur_k = 0; cur_b = 0;
         @(posedge clk); #1;
         apply_rand();
         for (int c = 0; c < 3000 && done_b < total; c++) begin
            @(negedge clk);
            exp_aw = '0;
            exp_w  = '0;
            if (in_data && bus.S_WREADY) exp_w[cur_m] = 1'b1;
            chk("rnd_m_wready", 64'(bus.M_WREADY), 64'(exp_w));
            chk("rnd_s_wvalid", 64'(bus.S_WVALID), 64'(in_data && bus.M_WVALID[cur_m]));
            if (bus.S_WVALID && bus.S_WREADY) begin
               chk("rnd_wdata", bus.S_WDATA,        wpat(cur_m, cur_k, cur_b));
               chk("rnd_wstrb", 64'(bus.S_WSTRB),   64'(spat(cur_m, cur_k, cur_b)));
               chk("rnd_wlast", 64'(bus.S_WLAST),   64'(cur_b == lens[cur_m][cur_k]));
               if (cur_b == lens[cur_m][cur_k]) begin
                  in_data = 0;
                  done_b++;
               end
               cur_b++;
            end
            if (bus.S_AWVALID && bus.S_AWREADY) begin
               exp_m = -1;
               for (int j = 0; j < N; j++) begin
                  cand = (ptr + j) % N;
                  if (exp_m < 0 && served[cand] < nb[cand]) exp_m = cand;
               end
               if (exp_m < 0) begin
                  chk("rnd_aw_extra", 64'(bus.S_AWVALID), 64'd0);
                  exp_m = 0;
               end
               exp_aw[exp_m] = 1'b1;
               chk("rnd_awid",   64'(bus.S_AWID),   64'({2'(exp_m), idof(exp_m, served[exp_m])}));
               chk("rnd_awaddr", 64'(bus.S_AWADDR), 64'(adof(exp_m, served[exp_m])));
               chk("rnd_awlen",  64'(bus.S_AWLEN),  64'(lens[exp_m][served[exp_m]]));
               cur_m = exp_m;
               cur_k = served[exp_m];
               cur_b = 0;
               served[exp_m]++;
               ptr = (exp_m + 1) % N;
               in_data = 1;
            end
            chk("rnd_m_awready", 64'(bus.M_AWREADY), 64'(exp_aw));
            for (int i = 0; i < N; i++) begin
               aw_hs[i] = bus.M_AWVALID[i] && bus.M_AWREADY[i];
               w_hs[i]  = bus.M_WVALID[i] && bus.M_WREADY[i];
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
               if (aw_hs[i]) ak[i]++;
               if (w_hs[i]) begin
                  if (wb[i] == lens[i][wk[i]]) begin
                     wk[i]++;
                     wb[i] = 0;
                  end else wb[i]++;
               end
            end
            apply_rand();
         end
         chk("rnd_all_bursts", 64'(done_b), 64'(total));
         @(negedge clk);
         chk("rnd_end_idle", 64'(bus.BUSY), 64'd0);
      end

`ifdef AXI4_ARB_BEAT_CHECK_EN
      // Master flags WLAST on the first of two beats: counter ends the burst, error is sticky.
      do_reset();
      @(posedge clk); #1;
      drv_aw(0, 1'b1, 4'h3, 32'h3000, 8'd1);
      drv_w(0, 1'b1, wpat(0, 0, 0), 8'hFF, 1'b1);
      bus.S_AWREADY = 1'b1;
      bus.S_WREADY  = 1'b1;
      beats = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         aw_acc = bus.M_AWREADY[0];
         if (bus.S_WVALID && bus.S_WREADY) begin
            chk("bc_wlast", 64'(bus.S_WLAST), 64'(beats == 1));
            beats++;
         end else if (beats == 2 && !bus.BUSY) break;
         @(posedge clk); #1;
         if (aw_acc) bus.M_AWVALID[0] = 1'b0;
         drv_w(0, (beats < 2), wpat(0, 0, beats), 8'hFF, (beats == 0));
      end
      chk("bc_beats", 64'(beats),         64'd2);
      chk("bc_idle",  64'(bus.BUSY),      64'd0);
      chk("bc_err",   64'(bus.WLAST_ERR), 64'd1);
      repeat (3) @(negedge clk);
      chk("bc_err_sticky", 64'(bus.WLAST_ERR), 64'd1);
      do_reset();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
